// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding and sizing for the divide sequencer
package div_seq_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W = $clog2(DIV_WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);
    logic [W:0] sh;
    logic [W:0] diff;
    logic       ge;
    // shift {rem,quo} left, trial-subtract, keep difference when no borrow
    always_comb begin
        sh       = {rem, quo[W-1]};
        diff     = sh - {1'b0, divisor};
        ge       = sh >= {1'b0, divisor};
        rem_next = ge ? diff[W-1:0] : sh[W-1:0];
        quo_next = {quo[W-2:0], ge};
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU sequencer that stalls the PC and writes LO/HI
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_div,
    input  logic             i_divu,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             pc_stall,
    output logic             busy,
    output logic             lo_we,
    output logic             hi_we,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic             busy_q, busy_d, we_q, we_d;
    logic             start;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    div_step #(.W(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_next(rem_nx),
        .quo_next(quo_nx)
    );

    assign start    = i_div | i_divu;
    assign pc_stall = rst_n & ((state_q == RUN) | ((state_q == IDLE) & start));
    assign busy     = busy_q;
    assign lo_we    = we_q;
    assign hi_we    = we_q;
    assign lo_out   = lo_q;
    assign hi_out   = hi_q;

    // next state: latch magnitudes on start, iterate in RUN, sign-fix the final step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    neg_a_d = i_div & rs_val[WIDTH-1];
                    neg_b_d = i_div & rt_val[WIDTH-1];
                    quo_d   = neg_a_d ? -rs_val : rs_val;
                    dvs_d   = neg_b_d ? -rt_val : rt_val;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    lo_d    = (dvs_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -quo_nx : quo_nx);
                    hi_d    = neg_a_q ? -rem_nx : rem_nx;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        we_d   = state_d == DONE;
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of the divide sequencer
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_div, i_divu;
    logic [31:0] rs_val, rt_val;
    logic        pc_stall, busy, lo_we, hi_we;
    logic [31:0] lo_out, hi_out;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pulse_cyc = 0;
    int          prev_pulse = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_div   (i_div),
        .i_divu  (i_divu),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .pc_stall(pc_stall),
        .busy    (busy),
        .lo_we   (lo_we),
        .hi_we   (hi_we),
        .lo_out  (lo_out),
        .hi_out  (hi_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one divide at the current negedge and follow it through DONE
    task automatic run_div(input string tag, input logic d, input logic du,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_lo, input logic [31:0] e_hi, input bit scr);
        int n;
        n = 0;
        i_div = d; i_divu = du; rs_val = a; rt_val = b;
        #1;
        while (pc_stall && n < 100) begin
            n++;
            @(negedge clk);
            i_div = 1'b0; i_divu = 1'b0;
            if (scr) begin
                rs_val = $urandom;
                rt_val = $urandom;
            end
            #1;
            if (n == 1) chk({tag, " busy"}, {31'b0, busy}, 32'd1);
        end
        chk({tag, " stall_cycles"}, n, 32'd33);
        chk({tag, " lo_we"}, {31'b0, lo_we}, 32'd1);
        chk({tag, " hi_we"}, {31'b0, hi_we}, 32'd1);
        chk({tag, " lo_out"}, lo_out, e_lo);
        chk({tag, " hi_out"}, hi_out, e_hi);
        prev_pulse = pulse_cyc;
        pulse_cyc = cyc;
        rs_val = '0; rt_val = '0;
        @(negedge clk);
        #1;
        chk({tag, " we_drop"}, {31'b0, lo_we}, 32'd0);
        chk({tag, " hold_lo"}, lo_out, e_lo);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; i_div = 1'b0; i_divu = 1'b1; rs_val = 32'd1; rt_val = 32'd1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst pc_stall", {31'b0, pc_stall}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst lo_we", {31'b0, lo_we}, 32'd0);
        chk("rst hi_we", {31'b0, hi_we}, 32'd0);
        chk("rst lo_out", lo_out, 32'd0);
        chk("rst hi_out", hi_out, 32'd0);
        i_divu = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_div("divu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("div_m7_2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_div("divu_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);
        run_div("div_ovf", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        run_div("divu_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0);
        run_div("div_m5_0", 1'b1, 1'b0, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
        run_div("both_strobes", 1'b1, 1'b1, 32'hFFFFFFFC, 32'd2, 32'hFFFFFFFE, 32'd0, 1'b0);
        // reset in the middle of a run
        i_divu = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
        repeat (10) begin
            @(negedge clk);
            i_divu = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst lo_out", lo_out, 32'd0);
        chk("midrst hi_out", hi_out, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (lo_we || hi_we) seen++;
        end
        chk("midrst no_write", seen, 32'd0);
        chk("midrst idle_stall", {31'b0, pc_stall}, 32'd0);
        run_div("after_rst_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        // back-to-back with operand scrambling during RUN
        run_div("b2b_divu_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b1);
        run_div("b2b_div_m9_3", 1'b1, 1'b0, 32'hFFFFFFF7, 32'd3, 32'hFFFFFFFD, 32'd0, 1'b1);
        chk("b2b pulse_spacing", pulse_cyc - prev_pulse, 32'd34);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the DIV/DIVU path of the CPU. It starts on the decoded divide strobes and runs a radix-2 restoring division over a fixed number of cycles. While it runs, it holds the PC. On completion it delivers quotient/remainder to LO/HI with one-cycle write strobes. It replaces the start/busy/over handshake between the decoder and an external divider with a single self-contained block.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_div  in  1  decoded DIV (signed); held stable by the fetch stall.
- i_divu  in  1  decoded DIVU (unsigned).
- rs_val  in  WIDTH  dividend, sampled only at start.
- rt_val  in  WIDTH  divisor, sampled only at start.
- pc_stall  out  1  hold PC/IR this cycle (combinational).
- busy  out  1  registered; high in RUN.
- lo_we  out  1  one-cycle LO write strobe.
- hi_we  out  1  one-cycle HI write strobe.
- lo_out  out  WIDTH  quotient; valid when lo_we.
- hi_out  out  WIDTH  remainder; valid when hi_we.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start = i_div | i_divu.
  - On start: latch operands, signed flag, and sign bits, then go to RUN.
  - In signed mode, latch magnitudes (two's-complement negate of negative operands; 0x80000000 stays 0x80000000 as unsigned magnitude).
  - Clear the remainder accumulator and counter.
- If both strobes are high, i_div wins (signed).
- RUN: one restoring step per cycle.
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor from rem.
  - If no borrow, keep the difference and set the quo LSB.
  - The counter increments. After step WIDTH-1, go to DONE.
- DONE:
  - Apply sign fixup: negate quotient if signs differ; negate remainder if dividend was negative. Unsigned mode never fixes up.
  - Drive lo_out/hi_out, pulse lo_we/hi_we, then go to IDLE.
  - Strobes are ignored in DONE; the PC advances this cycle, so no restart of the same instruction.
- Divide by zero (both modes): lo_out = all ones, hi_out = rs_val as sampled. Full latency still applies; no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo_out = 0x80000000, hi_out = 0.

## Timing
- pc_stall = (IDLE & start) | RUN. It is low in DONE and forced low while rst_n = 0.
- Start cycle T0 (IDLE). RUN occupies T1..T(WIDTH). DONE is T(WIDTH+1).
- pc_stall is high for WIDTH+1 cycles in total; results are written in cycle WIDTH+1 (33 for the default).
- lo_we/hi_we are registered outputs, high exactly one cycle per division, always together.
- lo_out/hi_out hold their last result until the next DONE.
- Back-to-back divides: a new start is accepted in the IDLE cycle after DONE (zero dead cycles beyond DONE→IDLE).
- Reset values: state IDLE, busy 0, lo_we 0, hi_we 0, lo_out 0, hi_out 0, counter 0.
- Reset asserted mid-RUN: next edge returns to IDLE with no write strobe. The partial result is discarded.
- rs_val/rt_val changes after T0 have no effect.

## Structure
- Package div_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - DIV_WIDTH = 32
  - counter width = $clog2(DIV_WIDTH)
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; the sequencer owns all registers.
- The sign-fixup negation is inline in the top module.

## Test plan
- DIVU 100 / 7 → pc_stall high 33 cycles, then lo_we = hi_we = 1 for one cycle with lo_out = 14, hi_out = 2.
- DIV 0xFFFFFFF9 (-7) / 2 → lo_out = 0xFFFFFFFD (-3), hi_out = 0xFFFFFFFF (-1). DIVU of the same operands → lo_out = 0x7FFFFFFC, hi_out = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo_out = 0x80000000, hi_out = 0. DIVU 5 / 0 → lo_out = 0xFFFFFFFF, hi_out = 5, after 33 stall cycles.
- rst_n low at T10 of a DIVU 100 / 7:
  - busy = 0 next cycle; no lo_we/hi_we ever seen.
  - lo_out = hi_out = 0.
  - A following DIVU 9 / 3 yields lo_out = 3, hi_out = 0.
- Back-to-back DIVU 9 / 3 then DIV 0xFFFFFFF7 / 3:
  - Two write pulses, 34 cycles apart.
  - Results (3, 0) then (0xFFFFFFFD, 0).
  - rs_val/rt_val scrambled every cycle during RUN without effect.
- i_div and i_divu both high with 0xFFFFFFFC / 2 → signed result lo_out = 0xFFFFFFFE, hi_out = 0.
